ste_joypad_scanner: RTL and testbench

//  Autonomous scan controller for the two STE enhanced joystick ports (4x matrix pads).

---
 rtl/ste_joypad_scanner.sv | 191 +++++++++++++++++++
 tb/tb_ste_joypad_scanner.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/ste_joypad_scanner.sv
// ste_joypad_scanner
// Autonomous row scanner for the two STE enhanced joystick ports. The FSM walks
// rows 0..3, holds each active-low row select for SETTLE_CYCLES cycles, samples
// the direction and fire return lines into shadow registers, and moves straight
// on to the next row. The CPU reads the shadows through a small register window.
//
// Build option: define STE_JOY_DEBOUNCE_EN to require two consecutive equal
// samples of a row before its shadow is updated.
//
// Bus behaviour: reads are combinational from registers whenever sel && rw.
// Writes are accepted on the clock edge when sel && !rw && lds. A write has no
// wait states and no acknowledge. uds is accepted but not used.
module ste_joypad_scanner #(
  parameter int SETTLE_CYCLES = 32,
  parameter int CNT_W         = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] din,
  input  logic        sel,
  input  logic [4:0]  addr,
  input  logic        uds,
  input  logic        lds,
  input  logic        rw,
  output logic [15:0] dout,
  output logic [7:0]  pad_sel_o,
  input  logic [7:0]  pad_dir_i,
  input  logic [1:0]  pad_fire_i,
  output logic        frame_done
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DRIVE  = 2'd1,
    SAMPLE = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);

  state_t           state;
  logic [1:0]       row;
  logic [CNT_W-1:0] cnt;

  logic [7:0]       dir_sh [4];
  logic [7:0]       fire_sh;

  logic             scan_en;
  logic             frame_tgl;
  logic             view_valid;
  logic [1:0]       view_idx;

  logic             wr_lo;
  logic             wr_ctrl;
  logic             wr_view;
  logic             scan_en_nxt;
  logic             sample_ok;
  logic             commit_dir;
  logic             commit_fire;

  logic             unused_bits;
  assign unused_bits = &{1'b0, uds, din[15:4]};

  // Both ports get the same select: the active row is pulled low.
  function automatic logic [7:0] row_select(input logic [1:0] r);
    logic [3:0] hot;
    hot = 4'b0001 << r;
    return {~hot, ~hot};
  endfunction

  assign wr_lo   = sel && !rw && lds;
  assign wr_ctrl = wr_lo && (addr == 5'h04);
  assign wr_view = wr_lo && (addr == 5'h02);

  // A clear of scan_en written during SAMPLE must already block that commit.
  assign scan_en_nxt = wr_ctrl ? din[0] : scan_en;
  assign sample_ok   = (state == SAMPLE) && scan_en_nxt;

`ifdef STE_JOY_DEBOUNCE_EN
  logic [7:0] pend_dir  [4];
  logic [1:0] pend_fire [4];

  assign commit_dir  = sample_ok && (pad_dir_i  == pend_dir[row]);
  assign commit_fire = sample_ok && (pad_fire_i == pend_fire[row]);

  // Pending registers remember the last raw sample taken for each row.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 4; i++) begin
        pend_dir[i]  <= 8'hff;
        pend_fire[i] <= 2'b11;
      end
    end else if (sample_ok) begin
      pend_dir[row]  <= pad_dir_i;
      pend_fire[row] <= pad_fire_i;
    end
  end
`else
  assign commit_dir  = sample_ok;
  assign commit_fire = sample_ok;
`endif

  // Scan FSM: row sequencing, settle counter, select outputs, frame pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      row        <= 2'd0;
      cnt        <= '0;
      pad_sel_o  <= 8'hff;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (!scan_en_nxt) begin
        state     <= IDLE;
        row       <= 2'd0;
        cnt       <= '0;
        pad_sel_o <= 8'hff;
      end else begin
        case (state)
          IDLE: begin
            state     <= DRIVE;
            row       <= 2'd0;
            cnt       <= '0;
            pad_sel_o <= row_select(2'd0);
          end
          DRIVE: begin
            cnt <= cnt + 1'b1;
            if (cnt == CNT_LAST) state <= SAMPLE;
          end
          SAMPLE: begin
            row        <= row + 2'd1;
            cnt        <= '0;
            state      <= DRIVE;
            pad_sel_o  <= row_select(row + 2'd1);
            frame_done <= (row == 2'd3);
          end
          default: begin
            state     <= IDLE;
            row       <= 2'd0;
            cnt       <= '0;
            pad_sel_o <= 8'hff;
          end
        endcase
      end
    end
  end

  // Shadow registers seen by the CPU; updated only on a committed sample.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 4; i++) dir_sh[i] <= 8'hff;
      fire_sh <= 8'hff;
    end else begin
      if (commit_dir)  dir_sh[row]         <= pad_dir_i;
      if (commit_fire) fire_sh[2*row +: 2] <= pad_fire_i;
    end
  end

  // CPU-writable control: scan enable, view row, and the frame toggle bit.
  always_ff @(posedge clk) begin
    if (reset) begin
      scan_en    <= 1'b1;
      view_valid <= 1'b0;
      view_idx   <= 2'd0;
      frame_tgl  <= 1'b0;
    end else begin
      scan_en   <= scan_en_nxt;
      frame_tgl <= frame_tgl ^ frame_done;
      if (wr_view) begin
        view_valid <= ~&din[3:0];
        if      (!din[0]) view_idx <= 2'd0;
        else if (!din[1]) view_idx <= 2'd1;
        else if (!din[2]) view_idx <= 2'd2;
        else              view_idx <= 2'd3;
      end
    end
  end

  // Read mux; reads see register values, so a read in a commit cycle is pre-commit.
  always_comb begin
    dout = 16'h0000;
    if (sel && rw) begin
      case (addr)
        5'h00:   dout = {8'hff, fire_sh};
        5'h02:   dout = view_valid ? {dir_sh[view_idx], 8'hff} : 16'hffff;
        5'h04:   dout = {14'h0, frame_tgl, scan_en};
        default: dout = 16'h0000;
      endcase
    end
  end

endmodule

// File: tb/tb_ste_joypad_scanner.sv
// Directed bench for ste_joypad_scanner with SETTLE_CYCLES=4 (5 cycles per
// row, 20 cycles per frame). Expected values are hand-computed constants.
module tb_ste_joypad_scanner;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] din;
  logic        sel;
  logic [4:0]  addr;
  logic        uds;
  logic        lds;
  logic        rw;
  logic [15:0] dout;
  logic [7:0]  pad_sel_o;
  logic [7:0]  pad_dir_i;
  logic [1:0]  pad_fire_i;
  logic        frame_done;

  int n_chk  = 0;
  int n_fail = 0;

  logic [7:0] pat_tbl [4] = '{8'hee, 8'hdd, 8'hbb, 8'h77};

`ifdef STE_JOY_DEBOUNCE_EN
  localparam logic [15:0] EXP_ROW0_FE   = 16'hffff;
  localparam logic [15:0] EXP_FIRE_R2   = 16'hffff;
  localparam logic [15:0] EXP_GLITCH    = 16'hffff;
`else
  localparam logic [15:0] EXP_ROW0_FE   = 16'hfeff;
  localparam logic [15:0] EXP_FIRE_R2   = 16'hffef;
  localparam logic [15:0] EXP_GLITCH    = 16'h7fff;
`endif

  ste_joypad_scanner #(.SETTLE_CYCLES(4), .CNT_W(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .din        (din),
    .sel        (sel),
    .addr       (addr),
    .uds        (uds),
    .lds        (lds),
    .rw         (rw),
    .dout       (dout),
    .pad_sel_o  (pad_sel_o),
    .pad_dir_i  (pad_dir_i),
    .pad_fire_i (pad_fire_i),
    .frame_done (frame_done)
  );

  // Clock and run-time guard
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic rd_chk(input string tag, input logic [4:0] a, input logic [15:0] exp);
    sel = 1'b1; rw = 1'b1; addr = a; uds = 1'b1; lds = 1'b1;
    #1;
    chk(tag, dout, exp);
    sel = 1'b0; uds = 1'b0; lds = 1'b0;
  endtask

  task automatic rd_bit0(input string tag, input logic exp);
    sel = 1'b1; rw = 1'b1; addr = 5'h04; uds = 1'b1; lds = 1'b1;
    #1;
    chk(tag, {15'h0, dout[0]}, {15'h0, exp});
    sel = 1'b0; uds = 1'b0; lds = 1'b0;
  endtask

  task automatic wr(input logic [4:0] a, input logic [15:0] d, input logic l);
    sel = 1'b1; rw = 1'b0; addr = a; din = d; uds = 1'b1; lds = l;
    tick();
    sel = 1'b0; rw = 1'b1; din = 16'h0; uds = 1'b0; lds = 1'b0;
  endtask

  // Advance to the first cycle of a fresh row whose select equals v.
  task automatic wait_row_start(input logic [7:0] v);
    int b;
    b = 0;
    while (pad_sel_o == v && b < 100) begin tick(); b++; end
    while (pad_sel_o != v && b < 200) begin tick(); b++; end
    chk("wait_row", {8'h00, pad_sel_o}, {8'h00, v});
  endtask

  // Directed sequence
  initial begin
    reset = 1'b1; din = 16'h0; sel = 1'b0; addr = 5'h0; uds = 1'b0;
    lds = 1'b0; rw = 1'b1; pad_dir_i = 8'hff; pad_fire_i = 2'b11;
    repeat (3) tick();
    reset = 1'b0;

    // Reset state and idle-bus reads
    chk("rst_pad", {8'h00, pad_sel_o}, 16'h00ff);
    chk("rst_fd", {15'h0, frame_done}, 16'h0000);
    rd_chk("rst_rd00", 5'h00, 16'hffff);
    rd_chk("rst_rd02", 5'h02, 16'hffff);
    rd_chk("rst_rd04", 5'h04, 16'h0001);
    addr = 5'h04; rw = 1'b1; sel = 1'b0; #1;
    chk("nosel_rd", dout, 16'h0000);
    tick();
    chk("first_drive", {8'h00, pad_sel_o}, 16'h00ee);

    // One full frame of select sequencing, each row held 5 cycles
    for (int i = 0; i < 20; i++) begin
      chk("frame_pad", {8'h00, pad_sel_o}, {8'h00, pat_tbl[i/5]});
      chk("frame_fd0", {15'h0, frame_done}, 16'h0000);
      tick();
    end
    chk("fd_first", {15'h0, frame_done}, 16'h0001);
    chk("wrap_pad", {8'h00, pad_sel_o}, 16'h00ee);

    // frame_done is a single-cycle pulse every 20 cycles; frame_tgl follows it
    for (int j = 1; j <= 20; j++) begin
      tick();
      chk("fd_period", {15'h0, frame_done}, (j == 20) ? 16'h0001 : 16'h0000);
      if (j == 1) rd_chk("frame_tgl", 5'h04, 16'h0003);
    end

    // Direction on row 0 for one frame
    wait_row_start(8'hee);
    pad_dir_i = 8'hfe;
    repeat (5) tick();
    pad_dir_i = 8'hff;
    wr(5'h02, 16'h000e, 1'b1);
    rd_chk("row0_fe", 5'h02, EXP_ROW0_FE);
    wr(5'h02, 16'h000d, 1'b1);
    rd_chk("view_row1", 5'h02, 16'hffff);
    wr(5'h02, 16'h000f, 1'b1);
    rd_chk("view_none", 5'h02, 16'hffff);
    wr(5'h02, 16'h0000, 1'b1);
    rd_chk("view_lowest", 5'h02, EXP_ROW0_FE);

    // Ignored writes and unmapped reads
    wr(5'h04, 16'h0000, 1'b0);
    rd_bit0("lds0_ignored", 1'b1);
    wr(5'h06, 16'h0000, 1'b1);
    rd_chk("unmapped_rd", 5'h06, 16'h0000);
    rd_bit0("unmapped_wr", 1'b1);

    // Fire on row 2 lands in fire_sh[5:4]
    wait_row_start(8'hbb);
    pad_fire_i = 2'b10;
    repeat (5) tick();
    pad_fire_i = 2'b11;
    rd_chk("fire_row2", 5'h00, EXP_FIRE_R2);

    // Abort mid-row-1 drive, then restart
    wait_row_start(8'hdd);
    tick();
    wr(5'h04, 16'h0000, 1'b1);
    chk("abort_pad", {8'h00, pad_sel_o}, 16'h00ff);
    pad_dir_i = 8'h00; pad_fire_i = 2'b00;
    repeat (30) tick();
    chk("idle_pad", {8'h00, pad_sel_o}, 16'h00ff);
    rd_bit0("scan_off", 1'b0);
    rd_chk("abort_fire", 5'h00, EXP_FIRE_R2);
    wr(5'h02, 16'h000d, 1'b1);
    rd_chk("abort_dir1", 5'h02, 16'hffff);
    pad_dir_i = 8'hff; pad_fire_i = 2'b11;
    wr(5'h04, 16'h0001, 1'b1);
    chk("restart_pad", {8'h00, pad_sel_o}, 16'h00ee);

    // One-frame glitch on row 0, then a sustained value
    pad_dir_i = 8'h7f;
    repeat (5) tick();
    pad_dir_i = 8'hff;
    wr(5'h02, 16'h000e, 1'b1);
    rd_chk("glitch", 5'h02, EXP_GLITCH);
    repeat (20) tick();
    rd_chk("glitch_gone", 5'h02, 16'hffff);
    pad_dir_i = 8'h7f;
    repeat (45) tick();
    rd_chk("held_2frames", 5'h02, 16'h7fff);
    pad_dir_i = 8'hff;

    // Reset in the middle of a scan
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rst2_pad", {8'h00, pad_sel_o}, 16'h00ff);
    rd_chk("rst2_rd00", 5'h00, 16'hffff);
    rd_chk("rst2_rd02", 5'h02, 16'hffff);
    rd_chk("rst2_rd04", 5'h04, 16'h0001);

    // Final report
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
